// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter/sequencer: FSM encoding, per-pass step limit and
// the legal range of the requested shift-amount width.
package shift_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // Largest amount the shared 3-bit barrel shifter can apply in a single pass.
    localparam logic [2:0] StepMax = 3'd7;

    localparam int unsigned AmtWMin = 3;
    localparam int unsigned AmtWMax = 5;

endpackage

// File: rtl/Barrel_Revers_shifter.sv
// 8-bit logarithmic barrel shifter with zero fill; a left shift is done by reversing the
// operand around a right-shift core.
module Barrel_Revers_shifter (
    input  logic [7:0] data_in,
    input  logic [2:0] shamt,
    input  logic       dir,
    output logic [7:0] data_out
);

    logic [7:0] in_r;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;

    always_comb begin
        in_r = data_in;
        if (dir) begin
            for (int i = 0; i < 8; i++) begin
                in_r[i] = data_in[7 - i];
            end
        end
        s1 = shamt[0] ? {1'b0, in_r[7:1]} : in_r;
        s2 = shamt[1] ? {2'b0, s1[7:2]}   : s1;
        s3 = shamt[2] ? {4'b0, s2[7:4]}   : s2;
        data_out = s3;
        if (dir) begin
            for (int i = 0; i < 8; i++) begin
                data_out[i] = s3[7 - i];
            end
        end
    end

endmodule

// File: rtl/shift_rr_arb.sv
// Two-way round-robin grant: a lone valid wins, otherwise the side that did not win last.
module shift_rr_arb (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        if (valid0 && !valid1) begin
            grant = 1'b0;
        end else if (valid1 && !valid0) begin
            grant = 1'b1;
        end else begin
            grant = !last_grant;
        end
    end

endmodule

// File: rtl/shift_arb_seq.sv
// Two-requester shift controller: arbitrates, then walks one shared 3-bit barrel shifter over
// as many passes as the requested amount needs and holds the registered result until taken.
module shift_arb_seq
    import shift_pkg::*;
#(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             last_grant_q;
    logic [7:0]       work_q;
    logic [AMT_W-1:0] remaining_q;
    logic             dir_q;
    logic             id_q;
    logic [7:0]       rsp_data_q;
    logic             rsp_id_q;

    logic             grant;
    logic             accept;
    logic [2:0]       step;
    logic [AMT_W-1:0] remaining_sub;
    logic [7:0]       shifted;

    shift_rr_arb u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    Barrel_Revers_shifter u_shifter (
        .data_in  (work_q),
        .shamt    (step),
        .dir      (dir_q),
        .data_out (shifted)
    );

    always_comb begin
        req0_ready    = (state_q == StIdle) && !grant;
        req1_ready    = (state_q == StIdle) && grant;
        accept        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        step          = (remaining_q > AMT_W'(StepMax)) ? StepMax : remaining_q[2:0];
        remaining_sub = remaining_q - AMT_W'(step);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (remaining_sub == '0) state_d = StDone;
            StDone:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            work_q       <= 8'h00;
            remaining_q  <= '0;
            dir_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && accept) begin
                work_q       <= grant ? req1_data : req0_data;
                remaining_q  <= grant ? req1_amt : req0_amt;
                dir_q        <= grant ? req1_dir : req0_dir;
                id_q         <= grant;
                last_grant_q <= grant;
            end else if (state_q == StShift) begin
                work_q      <= shifted;
                remaining_q <= remaining_sub;
                // Result is captured from the final pass so rsp_data is always a register.
                if (remaining_sub == '0) begin
                    rsp_data_q <= shifted;
                    rsp_id_q   <= id_q;
                end
            end
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arb_seq.sv
// Directed and randomized bench for shift_arb_seq against a plain arithmetic shift model.
module tb_shift_arb_seq;

    localparam int unsigned AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic [7:0]       req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_dir;
    logic             req1_valid;
    logic             req1_ready;
    logic [7:0]       req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_dir;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_id;
    logic             busy;

    int total;
    int bad;

    shift_arb_seq #(.AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_shift(input int d, input int a, input bit left);
        int r;
        r = left ? (d << a) : (d >> a);
        return 8'(r & 255);
    endfunction

    function automatic int model_latency(input int a);
        int passes;
        passes = (a == 0) ? 1 : (a + 6) / 7;
        return passes + 1;
    endfunction

    // Pulses reset, checks the reset-state outputs, and releases on a falling edge.
    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready0", 32'(req0_ready), 1);
        check("rst_ready1", 32'(req1_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one op on requester `who` (entered at a falling edge) and checks the response.
    task automatic do_op(input int who, input int d, input int a, input bit left,
                         input int hold);
        int lat;
        logic [7:0] exp_data;
        exp_data = model_shift(d, a, left);
        if (who == 0) begin
            req0_valid = 1'b1; req0_data = 8'(d); req0_amt = AMT_W'(a); req0_dir = left;
        end else begin
            req1_valid = 1'b1; req1_data = 8'(d); req1_amt = AMT_W'(a); req1_dir = left;
        end
        rsp_ready = 1'b0;
        #1;
        check("op_ready", 32'(who == 0 ? req0_ready : req1_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("shift_readys_low", 32'({req0_ready, req1_ready}), 0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("op_latency", 32'(lat), 32'(model_latency(a)));
        check("op_rsp_data", 32'(rsp_data), 32'(exp_data));
        check("op_rsp_id", 32'(rsp_id), 32'(who));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_busy", 32'(busy), 1);
            check("hold_readys", 32'({req0_ready, req1_ready}), 0);
            check("hold_data", 32'({rsp_id, rsp_data}), 32'({who[0], exp_data}));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("done_valid_drop", 32'(rsp_valid), 0);
        check("done_busy_drop", 32'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        int ops;
        int cycles;
        int g;
        int idq[$];
        total = 0;
        bad   = 0;
        req0_data = 8'h00; req0_amt = '0; req0_dir = 1'b0;
        req1_data = 8'h00; req1_amt = '0; req1_dir = 1'b0;

        // Directed single, multi-pass, zero amount and backpressure cases.
        do_reset();
        do_op(0, 8'hB5, 3, 1'b1, 0);
        check("b5_value", 32'(rsp_data), 32'h A8);
        do_op(1, 8'hFF, 9, 1'b0, 0);
        do_op(0, 8'h5A, 0, 1'b0, 0);
        do_op(0, 8'h5A, 0, 1'b1, 0);
        do_op(1, 8'h3C, 15, 1'b1, 0);
        do_op(0, 8'hC3, 6, 1'b0, 5);

        // Contention: both valid continuously, amt 1; expect strict alternation from req0.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h81; req0_amt = AMT_W'(1); req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h18; req1_amt = AMT_W'(1); req1_dir = 1'b1;
        rsp_ready  = 1'b1;
        ops = 0;
        cycles = 0;
        while (ops < 8 && cycles < 200) begin
            #1;
            if (rsp_valid && idq.size() > 0) begin
                check("cont_rsp_id", 32'(rsp_id), 32'(idq.pop_front()));
            end
            g = -1;
            if (req0_valid && req0_ready) g = 0;
            if (req1_valid && req1_ready) g = 1;
            if (g >= 0) begin
                check("cont_grant", 32'(g), 32'(ops % 2));
                idq.push_back(g);
                ops++;
            end
            @(negedge clk);
            cycles++;
        end
        check("cont_ops", 32'(ops), 8);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycles = 0;
        while (busy && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("cont_drain", 32'(busy), 0);
        rsp_ready = 1'b0;

        // Reset during a long op must discard it.
        req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = AMT_W'(15); req0_dir = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("mid_busy", 32'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready0", 32'(req0_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp", 32'({rsp_valid, busy}), 0);
        end
        @(negedge clk);
        do_op(0, 8'h01, 0, 1'b0, 0);

        // Randomized ops against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            do_op(int'($urandom_range(1, 0)), int'($urandom_range(255, 0)),
                  int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arb_seq.md
SHIFT_ARB_SEQ -- requirements
Module: shift_arb_seq

Interface
REQ-001 Parameter AMT_W, default 4, requested shift-amount width; legal range 3..5.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N offers an operation.
REQ-005 req0_ready / req1_ready  output  1  controller accepts requester N's operation this cycle.
REQ-006 req0_data / req1_data  input  8  operand.
REQ-007 req0_amt / req1_amt  input  AMT_W  total shift amount, unsigned.
REQ-008 req0_dir / req1_dir  input  1  0 = logical right, 1 = logical left; zero fill both ways.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_data  output  8  shifted result.
REQ-012 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The controller SHALL sequence one shared 8-bit bidirectional barrel shifter with a 3-bit amount and a direction select; no other shift logic exists.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 In IDLE, exactly one reqN_ready SHALL be high: the granted requester; in SHIFT and DONE, both readys SHALL be low.
REQ-017 Grant SHALL be round-robin: if only one valid, grant it; if both valid, grant the requester not recorded in last_grant; if none valid, grant points to !last_grant.
REQ-018 Grant and ready SHALL be combinational from the current-cycle valids and last_grant; a requester may drop valid without penalty before acceptance.
REQ-019 On valid&&ready: capture data into work register, amt into remaining counter, dir, and id; update last_grant to id; go to SHIFT.
REQ-020 Each SHIFT cycle SHALL apply step = min(remaining, 7) to the work register, then remaining -= step.
REQ-021 SHIFT SHALL move to DONE when the post-subtraction remaining is 0; otherwise it SHALL stay in SHIFT.
REQ-022 amt = 0 SHALL still take one SHIFT cycle and return the operand unchanged.
REQ-023 Passes = max(1, ceil(amt/7)); latency from accept edge to rsp_valid = passes + 1 cycles (amt 5: 2; amt 9: 3; amt 15: 4 at AMT_W=4).
REQ-024 amt >= 8 SHALL yield 0x00, obtained by the passes, not by shortcut.
REQ-025 In DONE, rsp_valid SHALL be high and rsp_data/rsp_id SHALL hold stable until rsp_valid&&rsp_ready; then go to IDLE.
REQ-026 No new request SHALL be accepted in the cycle the response completes; acceptance resumes the following cycle (throughput at most one op per passes + 2 cycles).
REQ-027 rsp_data and rsp_id SHALL be registered; shifter output SHALL never reach rsp_data combinationally.

Reset
REQ-028 While rst_n is low: state = IDLE, last_grant = 1 (req0 wins first contention), rsp_valid = 0, rsp_data = 0x00, rsp_id = 0, busy = 0, remaining = 0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation immediately and discard it; no response appears after release.
REQ-030 First acceptance is possible in the first rising edge after rst_n deasserts.

Structure
REQ-031 FSM state encoding, the 3-bit step maximum (7) and the AMT_W legal bounds SHALL live in a shared package shift_pkg.
REQ-032 The round-robin grant logic SHALL be one sub-module, shift_rr_arb (inputs: two valids, last_grant; output: grant index).
REQ-033 The datapath SHALL be an instance of the existing Barrel_Revers_shifter, driven by the work register, step and dir.

Verification
REQ-034 Single: req0 data 0xB5, amt 3, dir 1 -> rsp_data 0xA8, rsp_id 0, rsp_valid 2 cycles after accept.
REQ-035 Multi-pass: req1 data 0xFF, amt 9, dir 0 -> two SHIFT cycles, rsp_data 0x00, rsp_id 1, latency 3.
REQ-036 Contention: both valid continuously after reset, amt 1 each -> grant order 0,1,0,1; no starvation over 8 ops.
REQ-037 Backpressure: rsp_ready low 5 cycles in DONE -> rsp_data/rsp_id stable, both readys low, busy high throughout.
REQ-038 Reset mid-op: rst_n low during SHIFT of amt 15 -> rsp_valid 0, state IDLE; next op req0 0x01 amt 0 returns 0x01.
REQ-039 Zero amount: req0 data 0x5A, amt 0, either dir -> rsp_data 0x5A, latency 2.
